// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, flag indices, redirect states and tag age compare for ctrl_resolve_unit
package ctrl_pkg;

  localparam int OPC_W     = 4;
  localparam int FLAG_W    = 8;
  localparam int TAG_MAX_W = 32;

  localparam logic [OPC_W-1:0] OP_JUMP = 4'd0;
  localparam logic [OPC_W-1:0] OP_JAL  = 4'd1;
  localparam logic [OPC_W-1:0] OP_JR   = 4'd2;
  localparam logic [OPC_W-1:0] OP_JALR = 4'd3;
  localparam logic [OPC_W-1:0] OP_BEQ  = 4'd4;
  localparam logic [OPC_W-1:0] OP_BNE  = 4'd5;
  localparam logic [OPC_W-1:0] OP_BLEZ = 4'd6;
  localparam logic [OPC_W-1:0] OP_BGTZ = 4'd7;
  localparam logic [OPC_W-1:0] OP_BLTZ = 4'd8;
  localparam logic [OPC_W-1:0] OP_BGEZ = 4'd9;
  localparam logic [OPC_W-1:0] OP_BC1F = 4'd10;
  localparam logic [OPC_W-1:0] OP_BC1T = 4'd11;

  localparam int FLAG_EXEC = 7;
  localparam int FLAG_EXCP = 6;
  localparam int FLAG_COND = 5;
  localparam int FLAG_LINK = 4;
  localparam int FLAG_CTRL = 2;
  localparam int FLAG_MISP = 0;

  typedef enum logic {RD_IDLE, RD_HOLD} rd_state_e;

  // Callers pass tags left-aligned in TAG_MAX_W bits so the wrap-around MSB lands on the top bit.
  function automatic logic tag_older(input logic [TAG_MAX_W-1:0] a, input logic [TAG_MAX_W-1:0] b);
    logic [TAG_MAX_W-1:0] diff;
    diff = a - b;
    return diff[TAG_MAX_W-1];
  endfunction

endpackage

// File: rtl/ctrl_resolve_comb.sv
// rtl/ctrl_resolve_comb.sv - combinational jump/branch evaluation: direction, next PC, link value, flags
module ctrl_resolve_comb import ctrl_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int IMM_W    = 16,
  parameter int TARGET_W = 26
) (
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [IMM_W-1:0]  immd_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [PC_W-1:0]   predicted_target_i,
  input  logic              predicted_dir_i,
  output logic [PC_W-1:0]   result_o,
  output logic [PC_W-1:0]   next_pc_o,
  output logic              direction_o,
  output logic [FLAG_W-1:0] flags_o,
  output logic              mispredict_o
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(8);

  logic [PC_W-1:0] fall_pc;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] taken_pc;
  logic [PC_W-1:0] jump_pc;
  logic            a_neg;
  logic            a_zero;
  logic            is_branch;
  logic            taken;

  assign fall_pc  = pc_i + PC_STEP;
  assign offset   = {{(PC_W-IMM_W){immd_i[IMM_W-1]}}, immd_i} << 2;
  assign taken_pc = fall_pc + offset;
  assign jump_pc  = {pc_i[PC_W-1:TARGET_W+2], predicted_target_i[TARGET_W-1:0], 2'b00};
  assign a_neg    = data1_i[DATA_W-1];
  assign a_zero   = (data1_i == '0);

  always_comb begin
    result_o     = '0;
    next_pc_o    = fall_pc;
    direction_o  = 1'b0;
    flags_o      = '0;
    mispredict_o = 1'b0;
    is_branch    = 1'b0;
    taken        = 1'b0;
    flags_o[FLAG_EXEC] = 1'b1;

    case (opcode_i)
      OP_JUMP, OP_JAL: begin
        next_pc_o   = jump_pc;
        direction_o = 1'b1;
        flags_o[FLAG_CTRL] = 1'b1;
      end
      OP_JR, OP_JALR: begin
        next_pc_o    = data1_i;
        direction_o  = 1'b1;
        mispredict_o = (data1_i != predicted_target_i);
        flags_o[FLAG_CTRL] = 1'b1;
      end
      OP_BEQ:  begin is_branch = 1'b1; taken = (data1_i == data2_i); end
      OP_BNE:  begin is_branch = 1'b1; taken = (data1_i != data2_i); end
      OP_BLEZ: begin is_branch = 1'b1; taken = a_neg | a_zero;       end
      OP_BGTZ: begin is_branch = 1'b1; taken = !a_neg && !a_zero;    end
      OP_BLTZ: begin is_branch = 1'b1; taken = a_neg;                end
      OP_BGEZ: begin is_branch = 1'b1; taken = !a_neg;               end
      default: flags_o[FLAG_EXCP] = 1'b1;
    endcase

    if (opcode_i == OP_JAL || opcode_i == OP_JALR) begin
      result_o = fall_pc;
      flags_o[FLAG_LINK] = 1'b1;
    end

    if (is_branch) begin
      direction_o  = taken;
      next_pc_o    = taken ? taken_pc : fall_pc;
      mispredict_o = (taken != predicted_dir_i) || (taken && (taken_pc != predicted_target_i));
      flags_o[FLAG_COND] = 1'b1;
      flags_o[FLAG_CTRL] = 1'b1;
    end

    flags_o[FLAG_MISP] = mispredict_o;
  end

endmodule

// File: rtl/ctrl_resolve_unit.sv
// rtl/ctrl_resolve_unit.sv - registered control-transfer resolution with held front-end redirect
// Optional CTRL_RESOLVE_STATS_EN adds saturating branch/mispredict counters.
module ctrl_resolve_unit import ctrl_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int IMM_W    = 16,
  parameter int TARGET_W = 26,
  parameter int TAG_W    = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [IMM_W-1:0]  immd_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [PC_W-1:0]   predictedTarget_i,
  input  logic              predictedDir_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   result_o,
  output logic [PC_W-1:0]   nextPC_o,
  output logic              direction_o,
  output logic [FLAG_W-1:0] flags_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              redirect_valid_o,
  output logic [PC_W-1:0]   redirect_pc_o,
  output logic [TAG_W-1:0]  redirect_tag_o,
`ifdef CTRL_RESOLVE_STATS_EN
  output logic [31:0]       stat_branches_o,
  output logic [31:0]       stat_mispredicts_o,
`endif
  input  logic              redirect_ack_i
);

  logic [PC_W-1:0]   c_result;
  logic [PC_W-1:0]   c_next_pc;
  logic              c_dir;
  logic [FLAG_W-1:0] c_flags;
  logic              c_misp;

  ctrl_resolve_comb #(
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .IMM_W    (IMM_W),
    .TARGET_W (TARGET_W)
  ) u_comb (
    .opcode_i           (opcode_i),
    .data1_i            (data1_i),
    .data2_i            (data2_i),
    .immd_i             (immd_i),
    .pc_i               (pc_i),
    .predicted_target_i (predictedTarget_i),
    .predicted_dir_i    (predictedDir_i),
    .result_o           (c_result),
    .next_pc_o          (c_next_pc),
    .direction_o        (c_dir),
    .flags_o            (c_flags),
    .mispredict_o       (c_misp)
  );

  logic              out_valid_q, out_valid_d;
  logic [PC_W-1:0]   result_q, result_d;
  logic [PC_W-1:0]   next_pc_q, next_pc_d;
  logic              dir_q, dir_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic [PC_W-1:0]   rd_pc_q, rd_pc_d;
  logic [TAG_W-1:0]  rd_tag_q, rd_tag_d;

  logic accept;
  logic new_misp;
  logic new_older;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign new_misp   = accept && c_misp;
  assign new_older  = tag_older({tag_i,    {(TAG_MAX_W-TAG_W){1'b0}}},
                                {rd_tag_q, {(TAG_MAX_W-TAG_W){1'b0}}});

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    next_pc_d   = next_pc_q;
    dir_d       = dir_q;
    flags_d     = flags_q;
    tag_d       = tag_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = c_result;
      next_pc_d   = c_next_pc;
      dir_d       = c_dir;
      flags_d     = c_flags;
      tag_d       = tag_i;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // An older mispredict always takes over; a younger one only gets in once fetch has acked.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_pc_d    = rd_pc_q;
    rd_tag_d   = rd_tag_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (new_misp) begin
          rd_state_d = RD_HOLD;
          rd_pc_d    = c_next_pc;
          rd_tag_d   = tag_i;
        end
      end
      RD_HOLD: begin
        if (new_misp && (new_older || redirect_ack_i)) begin
          rd_pc_d  = c_next_pc;
          rd_tag_d = tag_i;
        end else if (redirect_ack_i) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      next_pc_q   <= '0;
      dir_q       <= 1'b0;
      flags_q     <= '0;
      tag_q       <= '0;
      rd_state_q  <= RD_IDLE;
      rd_pc_q     <= '0;
      rd_tag_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      next_pc_q   <= next_pc_d;
      dir_q       <= dir_d;
      flags_q     <= flags_d;
      tag_q       <= tag_d;
      rd_state_q  <= rd_state_d;
      rd_pc_q     <= rd_pc_d;
      rd_tag_q    <= rd_tag_d;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign result_o         = result_q;
  assign nextPC_o         = next_pc_q;
  assign direction_o      = dir_q;
  assign flags_o          = flags_q;
  assign tag_o            = tag_q;
  assign redirect_valid_o = (rd_state_q == RD_HOLD);
  assign redirect_pc_o    = rd_pc_q;
  assign redirect_tag_o   = rd_tag_q;

`ifdef CTRL_RESOLVE_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (accept && c_flags[FLAG_CTRL] && (stat_br_q != '1)) stat_br_d = stat_br_q + 32'd1;
    if (accept && c_flags[FLAG_MISP] && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches_o    = stat_br_q;
  assign stat_mispredicts_o = stat_mp_q;
`endif

endmodule

// File: tb/tb_ctrl_resolve_unit.sv
// tb/tb_ctrl_resolve_unit.sv - directed vector table plus redirect, backpressure and reset sequences
module tb_ctrl_resolve_unit;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [3:0]  opcode_i = '0;
  logic [31:0] data1_i = '0, data2_i = '0;
  logic [15:0] immd_i = '0;
  logic [31:0] pc_i = '0, predictedTarget_i = '0;
  logic        predictedDir_i = 1'b0;
  logic [5:0]  tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] result_o, nextPC_o;
  logic        direction_o;
  logic [7:0]  flags_o;
  logic [5:0]  tag_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [5:0]  redirect_tag_o;
  logic        redirect_ack_i = 1'b0;
`ifdef CTRL_RESOLVE_STATS_EN
  logic [31:0] stat_branches_o, stat_mispredicts_o;
`endif

  ctrl_resolve_unit dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .opcode_i          (opcode_i),
    .data1_i           (data1_i),
    .data2_i           (data2_i),
    .immd_i            (immd_i),
    .pc_i              (pc_i),
    .predictedTarget_i (predictedTarget_i),
    .predictedDir_i    (predictedDir_i),
    .tag_i             (tag_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .result_o          (result_o),
    .nextPC_o          (nextPC_o),
    .direction_o       (direction_o),
    .flags_o           (flags_o),
    .tag_o             (tag_o),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o),
    .redirect_tag_o    (redirect_tag_o),
`ifdef CTRL_RESOLVE_STATS_EN
    .stat_branches_o   (stat_branches_o),
    .stat_mispredicts_o(stat_mispredicts_o),
`endif
    .redirect_ack_i    (redirect_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1, d2;
    logic [15:0] immd;
    logic [31:0] pc, ptgt;
    logic        pdir;
    logic [31:0] e_res, e_npc;
    logic        e_dir;
    logic [7:0]  e_flags;
    logic        e_misp;
  } vec_t;

  vec_t vecs[15];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [15:0] immd, input logic [31:0] pc, input logic [31:0] ptgt,
                              input logic pdir, input logic [31:0] e_res, input logic [31:0] e_npc,
                              input logic e_dir, input logic [7:0] e_flags, input logic e_misp);
    vec_t v;
    v.op = op; v.d1 = d1; v.d2 = d2; v.immd = immd; v.pc = pc; v.ptgt = ptgt; v.pdir = pdir;
    v.e_res = e_res; v.e_npc = e_npc; v.e_dir = e_dir; v.e_flags = e_flags; v.e_misp = e_misp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [15:0] im, input logic [31:0] pc, input logic [31:0] pt,
                       input logic pd, input logic [5:0] tg);
    in_valid_i = 1'b1; opcode_i = op; data1_i = d1; data2_i = d2; immd_i = im;
    pc_i = pc; predictedTarget_i = pt; predictedDir_i = pd; tag_i = tg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(OP_BEQ,  32'd5, 32'd5, 16'h0004, 32'h100, 32'h118, 1'b1, 32'h0, 32'h118, 1'b1, 8'hA4, 1'b0);
    vecs[1]  = mk(OP_BEQ,  32'd5, 32'd6, 16'h0004, 32'h100, 32'h0,   1'b0, 32'h0, 32'h108, 1'b0, 8'hA4, 1'b0);
    vecs[2]  = mk(OP_BNE,  32'd5, 32'd6, 16'hFFFF, 32'h100, 32'h104, 1'b1, 32'h0, 32'h104, 1'b1, 8'hA4, 1'b0);
    vecs[3]  = mk(OP_BLEZ, 32'hFFFFFFFF, 32'd0, 16'h0008, 32'h300, 32'h0, 1'b0, 32'h0, 32'h328, 1'b1, 8'hA5, 1'b1);
    vecs[4]  = mk(OP_BGTZ, 32'd0, 32'd0, 16'h0002, 32'h40, 32'h50, 1'b1, 32'h0, 32'h48, 1'b0, 8'hA5, 1'b1);
    vecs[5]  = mk(OP_BGTZ, 32'd1, 32'd0, 16'h0002, 32'h40, 32'h50, 1'b1, 32'h0, 32'h50, 1'b1, 8'hA4, 1'b0);
    vecs[6]  = mk(OP_BLTZ, 32'h80000000, 32'd0, 16'h8000, 32'h1000, 32'h0, 1'b1, 32'h0, 32'hFFFE1008, 1'b1, 8'hA5, 1'b1);
    vecs[7]  = mk(OP_BGEZ, 32'd0, 32'd0, 16'h0001, 32'h2000, 32'h200C, 1'b1, 32'h0, 32'h200C, 1'b1, 8'hA4, 1'b0);
    vecs[8]  = mk(OP_BLTZ, 32'd0, 32'd0, 16'h0003, 32'h10, 32'h0, 1'b0, 32'h0, 32'h18, 1'b0, 8'hA4, 1'b0);
    vecs[9]  = mk(OP_JUMP, 32'd0, 32'd0, 16'h0, 32'hF0000000, 32'h123, 1'b0, 32'h0, 32'hF000048C, 1'b1, 8'h84, 1'b0);
    vecs[10] = mk(OP_JAL,  32'd0, 32'd0, 16'h0, 32'h12345670, 32'hFFFFFFFF, 1'b0, 32'h12345678, 32'h1FFFFFFC, 1'b1, 8'h94, 1'b0);
    vecs[11] = mk(OP_JR,   32'h400, 32'd0, 16'h0, 32'h200, 32'h400, 1'b0, 32'h0, 32'h400, 1'b1, 8'h84, 1'b0);
    vecs[12] = mk(OP_JALR, 32'h400, 32'd0, 16'h0, 32'h200, 32'h404, 1'b0, 32'h208, 32'h400, 1'b1, 8'h95, 1'b1);
    vecs[13] = mk(OP_BC1F, 32'd0, 32'd0, 16'h0, 32'h500, 32'h0, 1'b0, 32'h0, 32'h508, 1'b0, 8'hC0, 1'b0);
    vecs[14] = mk(4'hF,    32'd0, 32'd0, 16'h0, 32'hFFFFFFFC, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0, 8'hC0, 1'b0);

    // reset: an op presented while reset_n is low must not be taken
    drive(OP_JAL, 32'd0, 32'd0, 16'h0, 32'h700, 32'h0, 1'b0, 6'd1);
    repeat (3) step();
    chk("held_in_reset_out_valid", {31'd0, out_valid_o}, 32'd0);
    in_valid_i = 1'b0;
    reset_n = 1'b1;
    step();
    chk("reset_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("reset_redirect_valid", {31'd0, redirect_valid_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_nextpc", nextPC_o, 32'd0);
    chk("reset_flags", {24'd0, flags_o}, 32'd0);
    chk("reset_redirect_pc", redirect_pc_o, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready_o}, 32'd1);

    // vector table, back to back, ack held high so redirect tracks each op
    redirect_ack_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].op, vecs[i].d1, vecs[i].d2, vecs[i].immd, vecs[i].pc, vecs[i].ptgt, vecs[i].pdir, 6'(i));
      step();
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid_o}, 32'd1);
      chk($sformatf("v%0d_result", i), result_o, vecs[i].e_res);
      chk($sformatf("v%0d_nextpc", i), nextPC_o, vecs[i].e_npc);
      chk($sformatf("v%0d_direction", i), {31'd0, direction_o}, {31'd0, vecs[i].e_dir});
      chk($sformatf("v%0d_flags", i), {24'd0, flags_o}, {24'd0, vecs[i].e_flags});
      chk($sformatf("v%0d_tag", i), {26'd0, tag_o}, i);
      chk($sformatf("v%0d_redirect_valid", i), {31'd0, redirect_valid_o}, {31'd0, vecs[i].e_misp});
      if (vecs[i].e_misp)
        chk($sformatf("v%0d_redirect_pc", i), redirect_pc_o, vecs[i].e_npc);
    end
    in_valid_i = 1'b0;
    step();
    chk("table_drain_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("table_drain_redirect", {31'd0, redirect_valid_o}, 32'd0);
    redirect_ack_i = 1'b0;

    // JALR mispredict: redirect held until fetch acks, independent of output consumption
    drive(OP_JALR, 32'h400, 32'd0, 16'h0, 32'h200, 32'h404, 1'b0, 6'd20);
    step();
    in_valid_i = 1'b0;
    chk("jalr_result", result_o, 32'h208);
    chk("jalr_redirect_valid", {31'd0, redirect_valid_o}, 32'd1);
    chk("jalr_redirect_pc", redirect_pc_o, 32'h400);
    chk("jalr_redirect_tag", {26'd0, redirect_tag_o}, 32'd20);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("jalr_hold%0d_valid", k), {31'd0, redirect_valid_o}, 32'd1);
      chk($sformatf("jalr_hold%0d_pc", k), redirect_pc_o, 32'h400);
    end
    chk("jalr_out_consumed", {31'd0, out_valid_o}, 32'd0);
    redirect_ack_i = 1'b1;
    step();
    redirect_ack_i = 1'b0;
    chk("jalr_ack_release", {31'd0, redirect_valid_o}, 32'd0);

    // age ordering of competing mispredicts (BLEZ on -1, predicted not-taken)
    drive(OP_BLEZ, 32'hFFFFFFFF, 32'd0, 16'h0008, 32'h300, 32'h0, 1'b0, 6'd10);
    step();
    chk("age10_pc", redirect_pc_o, 32'h328);
    chk("age10_tag", {26'd0, redirect_tag_o}, 32'd10);
    drive(OP_BLEZ, 32'hFFFFFFFF, 32'd0, 16'h0008, 32'h700, 32'h0, 1'b0, 6'd12);
    step();
    chk("age12_ignored_pc", redirect_pc_o, 32'h328);
    chk("age12_ignored_tag", {26'd0, redirect_tag_o}, 32'd10);
    drive(OP_BLEZ, 32'hFFFFFFFF, 32'd0, 16'h0008, 32'h900, 32'h0, 1'b0, 6'd8);
    step();
    chk("age8_replace_pc", redirect_pc_o, 32'h928);
    chk("age8_replace_tag", {26'd0, redirect_tag_o}, 32'd8);
    in_valid_i = 1'b0;
    redirect_ack_i = 1'b1;
    step();
    redirect_ack_i = 1'b0;
    chk("age_ack_idle", {31'd0, redirect_valid_o}, 32'd0);
    drive(OP_BLEZ, 32'hFFFFFFFF, 32'd0, 16'h0008, 32'h100, 32'h0, 1'b0, 6'd2);
    step();
    chk("wrap2_tag", {26'd0, redirect_tag_o}, 32'd2);
    drive(OP_BLEZ, 32'hFFFFFFFF, 32'd0, 16'h0008, 32'hA00, 32'h0, 1'b0, 6'd62);
    step();
    chk("wrap62_tag", {26'd0, redirect_tag_o}, 32'd62);
    chk("wrap62_pc", redirect_pc_o, 32'hA28);
    drive(OP_BLEZ, 32'hFFFFFFFF, 32'd0, 16'h0008, 32'hB00, 32'h0, 1'b0, 6'd63);
    redirect_ack_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    chk("ack_younger_valid", {31'd0, redirect_valid_o}, 32'd1);
    chk("ack_younger_tag", {26'd0, redirect_tag_o}, 32'd63);
    chk("ack_younger_pc", redirect_pc_o, 32'hB28);
    step();
    redirect_ack_i = 1'b0;
    chk("ack_younger_release", {31'd0, redirect_valid_o}, 32'd0);

    // backpressure: output stalls 3 cycles, no op lost or duplicated
    drive(OP_JAL, 32'd0, 32'd0, 16'h0, 32'h0, 32'h0, 1'b0, 6'd30);
    step();
    chk("bp_first_result", result_o, 32'h8);
    out_ready_i = 1'b0;
    drive(OP_JAL, 32'd0, 32'd0, 16'h0, 32'h10, 32'h0, 1'b0, 6'd31);
    #1;
    chk("bp_in_ready_low", {31'd0, in_ready_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("bp_stall%0d_valid", k), {31'd0, out_valid_o}, 32'd1);
      chk($sformatf("bp_stall%0d_result", k), result_o, 32'h8);
      chk($sformatf("bp_stall%0d_tag", k), {26'd0, tag_o}, 32'd30);
      chk($sformatf("bp_stall%0d_in_ready", k), {31'd0, in_ready_o}, 32'd0);
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp_in_ready_comb", {31'd0, in_ready_o}, 32'd1);
    step();
    in_valid_i = 1'b0;
    chk("bp_second_result", result_o, 32'h18);
    chk("bp_second_tag", {26'd0, tag_o}, 32'd31);
    step();
    chk("bp_no_duplicate", {31'd0, out_valid_o}, 32'd0);

    // reset mid-operation with redirect held and output stalled
    out_ready_i = 1'b0;
    drive(OP_JALR, 32'h400, 32'd0, 16'h0, 32'h200, 32'h404, 1'b0, 6'd40);
    step();
    in_valid_i = 1'b0;
    chk("pre_reset_out_valid", {31'd0, out_valid_o}, 32'd1);
    chk("pre_reset_redirect", {31'd0, redirect_valid_o}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("async_reset_redirect", {31'd0, redirect_valid_o}, 32'd0);
    chk("async_reset_result", result_o, 32'd0);
    chk("async_reset_redirect_pc", redirect_pc_o, 32'd0);
`ifdef CTRL_RESOLVE_STATS_EN
    chk("async_reset_stat_branches", stat_branches_o, 32'd0);
    chk("async_reset_stat_mispredicts", stat_mispredicts_o, 32'd0);
`endif
    out_ready_i = 1'b1;
    drive(OP_JAL, 32'd0, 32'd0, 16'h0, 32'h800, 32'h0, 1'b0, 6'd41);
    step();
    chk("in_reset_not_accepted", {31'd0, out_valid_o}, 32'd0);
    in_valid_i = 1'b0;
    reset_n = 1'b1;
    step();
    chk("post_reset_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("post_reset_redirect", {31'd0, redirect_valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
